// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage RV32I pipeline.
// Tracks the destination/write/load info of the instructions in EX, MEM and WB.
// Using that info, it drives the EX operand forwarding selects, the
// load-use/RAW stalls and the branch/jump flushes. It also keeps saturating
// counters of stall cycles and flush cycles.
module pipe_hazard_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int FORWARD_EN     = 1,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic                      id_reg_write,
  input  logic                      id_mem_read,
  input  logic                      ex_pc_src,
  output logic                      stall_f,
  output logic                      stall_d,
  output logic                      flush_d,
  output logic                      flush_e,
  output logic [1:0]                fwd_a_e,
  output logic [1:0]                fwd_b_e,
  output logic [CNT_WIDTH-1:0]      stall_cnt,
  output logic [CNT_WIDTH-1:0]      flush_cnt
);

  // Counters never grow wider than the datapath that would export them.
  localparam int EFF_CNT_WIDTH = (CNT_WIDTH < DATA_WIDTH) ? CNT_WIDTH : DATA_WIDTH;

  logic [REG_ADDR_WIDTH-1:0] ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic                      ex_we, ex_ld, mem_we, wb_we;
  logic [1:0]                fwd_a, fwd_b;
  logic                      hazard;
  logic [EFF_CNT_WIDTH-1:0]  stall_q, flush_q;

  // A producer matches a source only if it writes a register other than x0.
  function automatic logic match(input logic                      we,
                                 input logic [REG_ADDR_WIDTH-1:0] rd,
                                 input logic [REG_ADDR_WIDTH-1:0] src);
    return we && (rd != '0) && (rd == src);
  endfunction

  // Forwarding selects and the raw hazard condition, from the shadow stages and ID.
  always_comb begin
    hazard = 1'b0;
    fwd_a  = 2'b00;
    fwd_b  = 2'b00;
    if (FORWARD_EN != 0) begin
      if (match(mem_we, mem_rd, ex_rs1))     fwd_a = 2'b10;
      else if (match(wb_we, wb_rd, ex_rs1))  fwd_a = 2'b01;
      if (match(mem_we, mem_rd, ex_rs2))     fwd_b = 2'b10;
      else if (match(wb_we, wb_rd, ex_rs2))  fwd_b = 2'b01;
      hazard = id_valid && ex_ld &&
               (match(ex_we, ex_rd, id_rs1) || match(ex_we, ex_rd, id_rs2));
    end else begin
      hazard = id_valid &&
               (match(ex_we,  ex_rd,  id_rs1) || match(ex_we,  ex_rd,  id_rs2) ||
                match(mem_we, mem_rd, id_rs1) || match(mem_we, mem_rd, id_rs2) ||
                match(wb_we,  wb_rd,  id_rs1) || match(wb_we,  wb_rd,  id_rs2));
    end
  end

  // Output priority: reset forces a flush, a taken branch beats a stall.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    fwd_a_e = fwd_a;
    fwd_b_e = fwd_b;
    if (rst) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      fwd_a_e = 2'b00;
      fwd_b_e = 2'b00;
    end else if (ex_pc_src) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (hazard) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  // Shadow pipeline: ID feeds EX (bubble on flush), EX and MEM shift every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_rs1 <= '0;
      ex_rs2 <= '0;
      ex_rd  <= '0;
      ex_we  <= 1'b0;
      ex_ld  <= 1'b0;
      mem_rd <= '0;
      mem_we <= 1'b0;
      wb_rd  <= '0;
      wb_we  <= 1'b0;
    end else begin
      ex_rs1 <= id_rs1;
      ex_rs2 <= id_rs2;
      ex_rd  <= id_rd;
      ex_we  <= id_valid && id_reg_write && !flush_e;
      ex_ld  <= id_valid && id_mem_read && !flush_e;
      mem_rd <= ex_rd;
      mem_we <= ex_we;
      wb_rd  <= mem_rd;
      wb_we  <= mem_we;
    end
  end

  // Saturating performance counters for stall cycles and redirect cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_d && (stall_q != '1))   stall_q <= stall_q + 1'b1;
      if (ex_pc_src && (flush_q != '1)) flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cnt = CNT_WIDTH'(stall_q);
  assign flush_cnt = CNT_WIDTH'(flush_q);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl.
// Three controllers share one ID/branch stimulus stream:
//   - forwarding enabled
//   - forwarding disabled
//   - forwarding enabled with 4-bit counters
// Each controller is compared every cycle against its own behavioural model.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_reg_write, id_mem_read, ex_pc_src;

  logic        sf [3];
  logic        sd [3];
  logic        fd [3];
  logic        fe [3];
  logic [1:0]  fa [3];
  logic [1:0]  fb [3];
  logic [15:0] sc0, sc1, fc0, fc1;
  logic [3:0]  sc2, fc2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .FORWARD_EN(1), .CNT_WIDTH(16)) u_fwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_pc_src(ex_pc_src), .stall_f(sf[0]), .stall_d(sd[0]), .flush_d(fd[0]),
    .flush_e(fe[0]), .fwd_a_e(fa[0]), .fwd_b_e(fb[0]), .stall_cnt(sc0), .flush_cnt(fc0));

  pipe_hazard_ctrl #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .FORWARD_EN(0), .CNT_WIDTH(16)) u_nofwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_pc_src(ex_pc_src), .stall_f(sf[1]), .stall_d(sd[1]), .flush_d(fd[1]),
    .flush_e(fe[1]), .fwd_a_e(fa[1]), .fwd_b_e(fb[1]), .stall_cnt(sc1), .flush_cnt(fc1));

  pipe_hazard_ctrl #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .FORWARD_EN(1), .CNT_WIDTH(4)) u_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_pc_src(ex_pc_src), .stall_f(sf[2]), .stall_d(sd[2]), .flush_d(fd[2]),
    .flush_e(fe[2]), .fwd_a_e(fa[2]), .fwd_b_e(fb[2]), .stall_cnt(sc2), .flush_cnt(fc2));

  // Reference model: one slot per in-flight instruction (0=EX, 1=MEM, 2=WB).
  typedef struct {
    logic       we;
    logic       ld;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } slot_t;

  slot_t pipe [3][3];
  int    mcnt_s [3];
  int    mcnt_f [3];
  bit    exp_sd [3];
  bit    exp_fe [3];
  int    fwd_cfg [3]  = '{1, 0, 1};
  int    cnt_max [3]  = '{65535, 65535, 15};
  string inst_name [3] = '{"fwd", "nofwd", "sat"};

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic bit writes_reg(slot_t s, logic [4:0] r);
    return s.we && (s.rd != 5'd0) && (s.rd == r);
  endfunction

  // Youngest producer wins: MEM result over WB result.
  function automatic logic [1:0] fwd_pick(int k, logic [4:0] r);
    if (fwd_cfg[k] == 0) return 2'b00;
    if (writes_reg(pipe[k][1], r)) return 2'b10;
    if (writes_reg(pipe[k][2], r)) return 2'b01;
    return 2'b00;
  endfunction

  // With forwarding only a load still in EX blocks; without it any producer in flight does.
  function automatic bit needs_stall(int k);
    int last;
    if (!id_valid) return 1'b0;
    last = (fwd_cfg[k] != 0) ? 0 : 2;
    for (int st = 0; st <= last; st++) begin
      if (writes_reg(pipe[k][st], id_rs1) || writes_reg(pipe[k][st], id_rs2)) begin
        if (fwd_cfg[k] == 0 || pipe[k][st].ld) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] obs_scnt(int k);
    case (k)
      0:       return 32'(sc0);
      1:       return 32'(sc1);
      default: return 32'(sc2);
    endcase
  endfunction

  function automatic logic [31:0] obs_fcnt(int k);
    case (k)
      0:       return 32'(fc0);
      1:       return 32'(fc1);
      default: return 32'(fc2);
    endcase
  endfunction

  task automatic checkCycle();
    bit e_sf, e_sd, e_fd, e_fe;
    logic [1:0] e_fa, e_fb;
    for (int k = 0; k < 3; k++) begin
      e_sf = 0; e_sd = 0; e_fd = 0; e_fe = 0;
      e_fa = fwd_pick(k, pipe[k][0].rs1);
      e_fb = fwd_pick(k, pipe[k][0].rs2);
      if (rst) begin
        e_fd = 1; e_fe = 1; e_fa = 2'b00; e_fb = 2'b00;
      end else if (ex_pc_src) begin
        e_fd = 1; e_fe = 1;
      end else if (needs_stall(k)) begin
        e_sf = 1; e_sd = 1; e_fe = 1;
      end
      exp_sd[k] = e_sd;
      exp_fe[k] = e_fe;
      checkOutput({inst_name[k], ".stall_f"}, 32'(sf[k]), 32'(e_sf));
      checkOutput({inst_name[k], ".stall_d"}, 32'(sd[k]), 32'(e_sd));
      checkOutput({inst_name[k], ".flush_d"}, 32'(fd[k]), 32'(e_fd));
      checkOutput({inst_name[k], ".flush_e"}, 32'(fe[k]), 32'(e_fe));
      checkOutput({inst_name[k], ".fwd_a"}, 32'(fa[k]), 32'(e_fa));
      checkOutput({inst_name[k], ".fwd_b"}, 32'(fb[k]), 32'(e_fb));
      checkOutput({inst_name[k], ".stall_cnt"}, obs_scnt(k), 32'(mcnt_s[k]));
      checkOutput({inst_name[k], ".flush_cnt"}, obs_fcnt(k), 32'(mcnt_f[k]));
    end
  endtask

  task automatic advanceModel();
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        for (int st = 0; st < 3; st++) begin
          pipe[k][st].we = 1'b0;
          pipe[k][st].ld = 1'b0;
        end
        mcnt_s[k] = 0;
        mcnt_f[k] = 0;
      end else begin
        if (exp_sd[k] && mcnt_s[k] < cnt_max[k]) mcnt_s[k]++;
        if (ex_pc_src && mcnt_f[k] < cnt_max[k]) mcnt_f[k]++;
        pipe[k][2] = pipe[k][1];
        pipe[k][1] = pipe[k][0];
        pipe[k][0].we  = id_valid && id_reg_write && !exp_fe[k];
        pipe[k][0].ld  = id_valid && id_mem_read && !exp_fe[k];
        pipe[k][0].rd  = id_rd;
        pipe[k][0].rs1 = id_rs1;
        pipe[k][0].rs2 = id_rs2;
      end
    end
  endtask

  // One cycle: drive ID, check mid-cycle, then step the model at the edge.
  task automatic applyStimulus(input bit v, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input bit rw, input bit mr,
                               input bit pc, input bit r);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_reg_write = rw; id_mem_read = mr; ex_pc_src = pc; rst = r;
    @(negedge clk);
    checkCycle();
    @(posedge clk);
    advanceModel();
    #1;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      for (int st = 0; st < 3; st++) pipe[k][st] = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0};
      mcnt_s[k] = 0; mcnt_f[k] = 0; exp_sd[k] = 0; exp_fe[k] = 0;
    end
    rst = 1'b1; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_reg_write = 0; id_mem_read = 0; ex_pc_src = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, then addi x5 / add x6,x5,x5 back to back and with a gap.
    applyStimulus(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1);
    applyStimulus(1, 5'd0, 5'd0, 5'd5, 1, 0, 0, 0);
    applyStimulus(1, 5'd5, 5'd5, 5'd6, 1, 0, 0, 0);
    applyStimulus(1, 5'd1, 5'd2, 5'd5, 1, 0, 0, 0);
    applyStimulus(1, 5'd3, 5'd4, 5'd9, 1, 0, 0, 0);
    applyStimulus(1, 5'd5, 5'd5, 5'd6, 1, 0, 0, 0);
    repeat (4) applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);

    // Load-use: lw x7 then add x8,x7,x0 held while stalled.
    applyStimulus(1, 5'd1, 5'd0, 5'd7, 1, 1, 0, 0);
    applyStimulus(1, 5'd7, 5'd0, 5'd8, 1, 0, 0, 0);
    applyStimulus(1, 5'd7, 5'd0, 5'd8, 1, 0, 0, 0);
    repeat (4) applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);

    // Writes to x0 never match a later read of x0.
    applyStimulus(1, 5'd1, 5'd0, 5'd0, 1, 1, 0, 0);
    applyStimulus(1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0);
    applyStimulus(1, 5'd0, 5'd0, 5'd3, 1, 0, 0, 0);
    repeat (3) applyStimulus(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);

    // Load-use coinciding with a taken branch.
    applyStimulus(1, 5'd1, 5'd0, 5'd7, 1, 1, 0, 0);
    applyStimulus(1, 5'd7, 5'd0, 5'd8, 1, 0, 1, 0);
    repeat (4) applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);

    // addi x5; add x6,x5,x0 held long enough for the no-forwarding stall to clear.
    applyStimulus(1, 5'd0, 5'd0, 5'd5, 1, 0, 0, 0);
    repeat (5) applyStimulus(1, 5'd5, 5'd0, 5'd6, 1, 0, 0, 0);

    // Saturation: reset, then 20 load-use pairs.
    applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 5'd1, 5'd0, 5'd7, 1, 1, 0, 0);
      applyStimulus(1, 5'd7, 5'd0, 5'd8, 1, 0, 0, 0);
    end
    checkOutput("sat.stall_cnt_hold", 32'(sc2), 32'd15);

    // Reset asserted in the load-use cycle drops the stall and clears counters.
    applyStimulus(1, 5'd1, 5'd0, 5'd7, 1, 1, 0, 0);
    applyStimulus(1, 5'd7, 5'd0, 5'd8, 1, 0, 0, 1);
    rst = 1'b0;
    #1;
    checkOutput("sat.stall_d_after_rst", 32'(sd[2]), 32'd0);
    checkOutput("sat.stall_cnt_after_rst", 32'(sc2), 32'd0);
    applyStimulus(1, 5'd7, 5'd0, 5'd8, 1, 0, 0, 0);

    // Randomized traffic over a small register set so hazards are frequent.
    for (int i = 0; i < 800; i++) begin
      applyStimulus($urandom_range(0, 99) < 85,
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)),
                    $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 35,
                    $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
